// File: rtl/condicionador_botoes.sv
// Conditions eight raw push-buttons: 2-flop synchronizer, per-button debounce FSM,
// one-cycle press pulses gated by habilita, and a saturating count of pulse cycles.
module condicionador_botoes #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] botoes_brutos,
    input  logic       habilita,
    input  logic       zerar_jogadas,
    output logic [7:0] botoes_pulso,
    output logic [7:0] botoes_estavel,
    output logic [7:0] jogadas
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } estado_t;

    logic [7:0] r_s1;
    logic [7:0] r_s2;
    logic [7:0] r_pulso;
    logic [7:0] r_estavel;
    logic [7:0] r_jogadas;
    logic [7:0] w_aceita;
    logic [7:0] w_estavel_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= botoes_brutos;
            r_s2 <= r_s1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_botao
            estado_t       r_estado;
            estado_t       w_estado_next;
            logic [CW-1:0] r_cont;
            logic [CW-1:0] w_cont_next;
            logic          w_aceita_bit;

            always_comb begin
                w_estado_next = r_estado;
                w_cont_next   = r_cont;
                w_aceita_bit  = 1'b0;
                case (r_estado)
                    IDLE: begin
                        if (r_s2[gi]) begin
                            w_estado_next = PRESS_WAIT;
                            w_cont_next   = '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!r_s2[gi]) begin
                            w_estado_next = IDLE;
                        end else if (r_cont == LAST) begin
                            w_estado_next = HELD;
                            w_aceita_bit  = 1'b1;
                        end else begin
                            w_cont_next = r_cont + CW'(1);
                        end
                    end
                    HELD: begin
                        if (!r_s2[gi]) begin
                            w_estado_next = RELEASE_WAIT;
                            w_cont_next   = '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        // A bounce back high returns to HELD silently: still the same press.
                        if (r_s2[gi]) begin
                            w_estado_next = HELD;
                        end else if (r_cont == LAST) begin
                            w_estado_next = IDLE;
                        end else begin
                            w_cont_next = r_cont + CW'(1);
                        end
                    end
                    default: begin
                        w_estado_next = IDLE;
                        w_cont_next   = '0;
                    end
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_estado <= IDLE;
                    r_cont   <= '0;
                end else begin
                    r_estado <= w_estado_next;
                    r_cont   <= w_cont_next;
                end
            end

            assign w_aceita[gi]       = w_aceita_bit;
            assign w_estavel_next[gi] = (w_estado_next == HELD) || (w_estado_next == RELEASE_WAIT);
        end
    endgenerate

    // FSMs keep tracking while disabled; only the pulse is masked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pulso   <= '0;
            r_estavel <= '0;
        end else begin
            r_pulso   <= habilita ? w_aceita : 8'h00;
            r_estavel <= w_estavel_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_jogadas <= '0;
        end else if (zerar_jogadas) begin
            r_jogadas <= '0;
        end else if ((r_pulso != 8'h00) && (r_jogadas != 8'hFF)) begin
            r_jogadas <= r_jogadas + 8'd1;
        end
    end

    assign botoes_pulso   = r_pulso;
    assign botoes_estavel = r_estavel;
    assign jogadas        = r_jogadas;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Randomized bench for condicionador_botoes: run-length reference model feeds a
// pulse scoreboard; a negedge monitor checks pulses, stable levels and move count.
module tb_condicionador_botoes;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] raw;
    logic       hab;
    logic       zerar;
    logic [7:0] pulso;
    logic [7:0] estavel;
    logic [7:0] jog;

    always #5 clk = ~clk;

    condicionador_botoes #(.DEBOUNCE_CYCLES(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .botoes_brutos (raw),
        .habilita      (hab),
        .zerar_jogadas (zerar),
        .botoes_pulso  (pulso),
        .botoes_estavel(estavel),
        .jogadas       (jog)
    );

    typedef struct {
        int unsigned cyc;
        logic [7:0]  pulse;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  m_s1, m_s2, m_stable, m_pulse_reg, m_p;
    int          m_run[8];
    int          m_jog;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    // Reference: a press is accepted once the synchronized level has been high for
    // D+1 consecutive samples while released; release likewise needs D+1 low samples.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_pulse_reg = '0; m_jog = 0;
            for (int k = 0; k < 8; k++) m_run[k] = 0;
            exp_q.delete();
        end else begin
            cyc++;
            m_p = '0;
            for (int k = 0; k < 8; k++) begin
                if (m_stable[k] == m_s2[k]) m_run[k] = 0;
                else m_run[k] = m_run[k] + 1;
                if (m_run[k] == D + 1) begin
                    m_run[k] = 0;
                    if (!m_stable[k] && hab) m_p[k] = 1'b1;
                    m_stable[k] = m_s2[k];
                end
            end
            if (zerar) m_jog = 0;
            else if (m_pulse_reg != 0 && m_jog < 255) m_jog = m_jog + 1;
            m_pulse_reg = m_p;
            if (m_p != 0) exp_q.push_back('{cyc, m_p});
            m_s2 = m_s1;
            m_s1 = raw;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (pulso != 8'h00) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pulso_inesperado cyc=%0d: got %h required 00", cyc, pulso);
            end else begin
                e = exp_q.pop_front();
                if (e.pulse !== pulso || e.cyc != cyc) begin
                    n_err++;
                    $display("FAIL pulso cyc=%0d: got %h required %h at cyc %0d", cyc, pulso, e.pulse, e.cyc);
                end else begin
                    $display("pulse ok cyc=%0d pulso=%h jogadas=%0d", cyc, pulso, jog);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL pulso_ausente cyc=%0d: got 00 required %h", cyc, e.pulse);
        end
        n_cmp++;
        if (estavel !== m_stable) begin
            n_err++;
            $display("FAIL estavel cyc=%0d: got %h required %h", cyc, estavel, m_stable);
        end
        n_cmp++;
        if (jog !== 8'(m_jog)) begin
            n_err++;
            $display("FAIL jogadas cyc=%0d: got %0d required %0d", cyc, jog, m_jog);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; raw = '0; hab = 1'b1; zerar = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);
        // single press and hold
        raw = 8'h01; tick(12); raw = 8'h00; tick(12);
        // glitch shorter than the debounce window
        raw = 8'h08; tick(3); raw = 8'h00; tick(10);
        // simultaneous press on two buttons
        raw = 8'h42; tick(12); raw = 8'h00; tick(12);
        // release bounce
        raw = 8'h04; tick(12); raw = 8'h00; tick(2); raw = 8'h04; tick(10); raw = 8'h00; tick(12);
        // press while disabled
        hab = 1'b0; raw = 8'h10; tick(12); hab = 1'b1; raw = 8'h00; tick(12);
        // saturation of the move counter
        for (int i = 0; i < 260; i++) begin
            raw = 8'h01 << $urandom_range(7);
            tick(8);
            raw = 8'h00;
            tick(8);
        end
        zerar = 1'b1; tick(1); zerar = 1'b0; tick(2);
        // reset while a press is pending, button kept held
        raw = 8'h20; tick(4); rst = 1'b1; tick(1); rst = 1'b0; tick(12); raw = 8'h00; tick(12);
        // random bouncing traffic
        for (int i = 0; i < 600; i++) begin
            raw   = raw ^ (8'($urandom) & 8'($urandom));
            hab   = ($urandom_range(7) != 0);
            zerar = ($urandom_range(40) == 0);
            rst   = ($urandom_range(150) == 0);
            tick($urandom_range(1, 9));
            rst   = 1'b0;
            zerar = 1'b0;
        end
        raw = 8'h00; hab = 1'b1;
        tick(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
